// File: rtl/pipe_pkg.sv
// Shared EX/MEM pipeline types: payload struct sized to the widest supported
// configuration and the skid-stage state encoding.
package pipe_pkg;

  localparam int unsigned PL_XLEN    = 64;
  localparam int unsigned PL_REG_AW  = 8;
  localparam int unsigned PL_WBSEL_W = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  // Instances narrower than the maximum keep the unused upper bits at zero.
  typedef struct packed {
    logic                  we;
    logic [PL_REG_AW-1:0]  rd;
    logic [PL_WBSEL_W-1:0] wbsel;
    logic [PL_XLEN-1:0]    pc;
    logic [PL_XLEN-1:0]    imm;
    logic [PL_XLEN-1:0]    data_b;
    logic [PL_XLEN-1:0]    alu_out;
  } ex_mem_pl_t;

endpackage

// File: rtl/pipe_reg_ex_mem_skid.sv
// EX/MEM pipeline register with a one-entry skid buffer so in_ready comes
// straight from a flop while still sustaining one transfer per cycle.
module pipe_reg_ex_mem_skid
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned WBSEL_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               ex_we,
  input  logic [REG_AW-1:0]  ex_rd,
  input  logic [WBSEL_W-1:0] ex_WBSel,
  input  logic [XLEN-1:0]    ex_pc,
  input  logic [XLEN-1:0]    ex_imm,
  input  logic [XLEN-1:0]    ex_DataB,
  input  logic [XLEN-1:0]    ex_ALU_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               mem_we,
  output logic [REG_AW-1:0]  mem_rd,
  output logic [WBSEL_W-1:0] mem_WBSel,
  output logic [XLEN-1:0]    mem_pc,
  output logic [XLEN-1:0]    mem_imm,
  output logic [XLEN-1:0]    mem_DataB,
  output logic [XLEN-1:0]    mem_ALU_out
);

  stage_state_e state_q, state_d;
  ex_mem_pl_t   main_q, main_d;
  ex_mem_pl_t   skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  ex_mem_pl_t   in_pl;
  logic         in_fire;
  logic         out_fire;

  // Incoming payload, widened to the storage format with x0 writes suppressed.
  always_comb begin
    in_pl         = '0;
    in_pl.we      = ex_we && (ex_rd != '0);
    in_pl.rd      = PL_REG_AW'(ex_rd);
    in_pl.wbsel   = PL_WBSEL_W'(ex_WBSel);
    in_pl.pc      = PL_XLEN'(ex_pc);
    in_pl.imm     = PL_XLEN'(ex_imm);
    in_pl.data_b  = PL_XLEN'(ex_DataB);
    in_pl.alu_out = PL_XLEN'(ex_ALU_out);
  end

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      state_d     = EMPTY;
      main_d      = '0;
      skid_d      = '0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d      = in_pl;
            state_d     = BUSY;
            out_valid_d = 1'b1;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_d = in_pl;
          end else if (in_fire) begin
            skid_d     = in_pl;
            state_d    = FULL;
            in_ready_d = 1'b0;
          end else if (out_fire) begin
            // Clear we on drain so mem_we stays low while nothing is valid.
            main_d.we   = 1'b0;
            state_d     = EMPTY;
            out_valid_d = 1'b0;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d     = skid_q;
            state_d    = BUSY;
            in_ready_d = 1'b1;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_d      = '0;
          skid_d      = '0;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign mem_we      = main_q.we;
  assign mem_rd      = REG_AW'(main_q.rd);
  assign mem_WBSel   = WBSEL_W'(main_q.wbsel);
  assign mem_pc      = XLEN'(main_q.pc);
  assign mem_imm     = XLEN'(main_q.imm);
  assign mem_DataB   = XLEN'(main_q.data_b);
  assign mem_ALU_out = XLEN'(main_q.alu_out);

endmodule

// File: doc/pipe_reg_ex_mem_skid.md
PIPE_REG_EX_MEM_SKID -- requirements
Module: pipe_reg_ex_mem_skid

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of pc, imm, DataB and ALU_out fields.
REQ-002 SHALL have parameter REG_AW, default 5: destination register index width.
REQ-003 SHALL have parameter WBSEL_W, default 2: write-back select width.
REQ-004 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-006 SHALL have port flush  input  1: synchronous kill of all held entries.
REQ-007 SHALL have port in_valid  input  1: EX payload valid.
REQ-008 SHALL have port in_ready  output  1: stage can accept; driven directly from a flop.
REQ-009 SHALL have ports ex_we (1), ex_rd (REG_AW), ex_WBSel (WBSEL_W), ex_pc, ex_imm, ex_DataB, ex_ALU_out (XLEN each), all inputs: EX payload.
REQ-010 SHALL have port out_valid  output  1: MEM payload valid.
REQ-011 SHALL have port out_ready  input  1: MEM accepts payload.
REQ-012 SHALL have ports mem_we, mem_rd, mem_WBSel, mem_pc, mem_imm, mem_DataB, mem_ALU_out, all outputs, widths matching the ex_ ports: MEM payload.

Function
REQ-013 SHALL accept an input transfer only when in_valid && in_ready, and complete an output transfer only when out_valid && out_ready.
REQ-014 SHALL hold two entries, main (drives mem_* and out_valid) and skid, with states EMPTY, BUSY and FULL.
REQ-015 EMPTY: on an input transfer, SHALL load main and go to BUSY; otherwise SHALL stay in EMPTY.
REQ-016 BUSY with input and output transfer: SHALL load main with the new payload and stay in BUSY (throughput 1/cycle).
REQ-017 BUSY with input only: SHALL load skid, go to FULL, and deassert in_ready on the next cycle.
REQ-018 BUSY with output only: SHALL go to EMPTY. With neither transfer, SHALL hold.
REQ-019 FULL: on an output transfer, SHALL copy skid into main, go to BUSY, and assert in_ready on the next cycle; otherwise SHALL hold all payload stable.
REQ-020 SHALL hold in_ready=1 in EMPTY and BUSY, and in_ready=0 in FULL.
REQ-021 SHALL present the payload at mem_* exactly one cycle after its input transfer when the stage was EMPTY or draining; there SHALL be no combinational path from ex_* or in_valid to any output.
REQ-022 SHALL store we=0 for any accepted entry with ex_rd==0 (x0 write suppression).
REQ-023 SHALL force mem_we to 0 whenever out_valid=0.
REQ-024 flush SHALL take effect next cycle with priority over all transfers in the same cycle: state EMPTY, out_valid=0, in_ready=1, all main and skid fields zeroed; an input presented in the flush cycle SHALL be discarded.
REQ-025 SHALL preserve arrival order; no payload is dropped or duplicated except as defined by flush and reset.

Reset
REQ-026 rst SHALL have priority over flush and produce the flush state: out_valid=0, in_ready=1, every mem_* output 0, skid zeroed, state EMPTY.
REQ-027 SHALL hold in_ready=1 in the cycle after rst deasserts; rst asserted in FULL SHALL discard both entries.

Structure
REQ-028 A shared package pipe_pkg SHALL hold the EX/MEM payload struct typedef, parameterised by XLEN, REG_AW and WBSEL_W (via parameterised type or package constants), and the state enum {EMPTY, BUSY, FULL}.
REQ-029 SHALL be a single module with no sub-module; main and skid SHALL be two instances of the payload struct type.

Verification
REQ-030 Streaming: out_ready=1, in_valid=1 for 8 cycles with ALU_out=1..8 -> mem_ALU_out=1..8 on consecutive cycles, 1-cycle latency, in_ready constantly 1.
REQ-031 Backpressure: out_ready=0 and send A=0x11, B=0x22 -> in_ready=0 after B, A held at output; then out_ready=1 -> A then B in order, in_ready=1 again one cycle after A leaves.
REQ-032 x0 suppression: ex_we=1, ex_rd=0 accepted -> mem_we=0 when out_valid=1; ex_rd=5 -> mem_we=1.
REQ-033 Flush in FULL while in_valid=1 carrying 0x33 -> next cycle out_valid=0, mem_we=0, in_ready=1; 0x33 never appears at the output.
REQ-034 Reset: rst=1 for 1 cycle while FULL with flush=1 -> all outputs 0, in_ready=1; the first payload after reset emerges 1 cycle after acceptance.
REQ-035 Parameter sweep: XLEN=64, REG_AW=6 -> REQ-030 and REQ-031 pass with the top bits of every field preserved.
